// File: rtl/reg_cmd_arbiter.sv
// reg_cmd_arbiter: round-robin arbiter for three command requesters
// sharing a single counter/register (inc, clear, load).
module reg_cmd_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [1:0]       op2,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [2:0]       gnt,
  output logic             inc,
  output logic             clr,
  output logic             write_en,
  output logic [WIDTH-1:0] dataout,
  output logic             busy
);

  logic [2:0]       gnt_q, gnt_d;
  logic             inc_q, inc_d;
  logic             clr_q, clr_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       last_q, last_d;

  logic [3:0]       elig;
  logic [1:0]       p0, p1, p2;
  logic [1:0]       win;
  logic             win_vld;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_dat;

  // The requester granted this cycle is masked out of the next round.
  assign elig = {1'b0,
                 req[2] & (op2 != 2'b00) & ~gnt_q[2],
                 req[1] & (op1 != 2'b00) & ~gnt_q[1],
                 req[0] & (op0 != 2'b00) & ~gnt_q[0]};

  // Search order starts just after the last winner and wraps 2->0.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_q)
      2'd0: begin
        p0 = 2'd1;
        p1 = 2'd2;
        p2 = 2'd0;
      end
      2'd1: begin
        p0 = 2'd2;
        p1 = 2'd0;
        p2 = 2'd1;
      end
      default: begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
      end
    endcase
  end

  // Pick the first eligible requester in search order.
  always_comb begin
    win_vld = 1'b1;
    win     = p0;
    if (elig[p0]) begin
      win = p0;
    end else if (elig[p1]) begin
      win = p1;
    end else if (elig[p2]) begin
      win = p2;
    end else begin
      win_vld = 1'b0;
      win     = last_q;
    end
  end

  // Mux the winner's op and data.
  always_comb begin
    win_op  = op0;
    win_dat = data0;
    case (win)
      2'd1: begin
        win_op  = op1;
        win_dat = data1;
      end
      2'd2: begin
        win_op  = op2;
        win_dat = data2;
      end
      default: begin
        win_op  = op0;
        win_dat = data0;
      end
    endcase
  end

  // Next-state: one-cycle grant pulse plus decoded command.
  always_comb begin
    gnt_d  = 3'b000;
    inc_d  = 1'b0;
    clr_d  = 1'b0;
    we_d   = 1'b0;
    busy_d = 1'b0;
    dout_d = dout_q;
    last_d = last_q;
    if (win_vld) begin
      gnt_d  = 3'b001 << win;
      last_d = win;
      busy_d = 1'b1;
      unique case (win_op)
        2'b01: inc_d = 1'b1;
        2'b10: clr_d = 1'b1;
        2'b11: begin
          we_d   = 1'b1;
          dout_d = win_dat;
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  // Output and arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q  <= 3'b000;
      inc_q  <= 1'b0;
      clr_q  <= 1'b0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      dout_q <= '0;
      last_q <= 2'd2;
    end else begin
      gnt_q  <= gnt_d;
      inc_q  <= inc_d;
      clr_q  <= clr_d;
      we_q   <= we_d;
      busy_q <= busy_d;
      dout_q <= dout_d;
      last_q <= last_d;
    end
  end

  assign gnt      = gnt_q;
  assign inc      = inc_q;
  assign clr      = clr_q;
  assign write_en = we_q;
  assign dataout  = dout_q;
  assign busy     = busy_q;

endmodule
